// File: rtl/avalon_mem_arb_if.sv
// Bundle of requestor-side, Avalon-MM master and write-snoop signals for avalon_mem_arb.
// The master modport is the arbiter's view; slave is the requestors plus memory side.
interface avalon_mem_arb_if #(
    parameter int NCH       = 4,
    parameter int DW        = 32,
    parameter int AW        = 30,
    parameter int BURST_MAX = 8
);
    localparam int BE = DW / 8;
    localparam int LW = $clog2(BURST_MAX) + 1;

    logic [NCH-1:0]    req_do;
    logic [NCH-1:0]    req_we;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*LW-1:0] req_len;
    logic [NCH*BE-1:0] req_be;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    wr_ack;
    logic [NCH-1:0]    rd_valid;
    logic [DW-1:0]     rd_data;
    logic [NCH-1:0]    done;

    logic [AW-1:0]     avm_address;
    logic [DW-1:0]     avm_writedata;
    logic [BE-1:0]     avm_byteenable;
    logic [LW-1:0]     avm_burstcount;
    logic              avm_write;
    logic              avm_read;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
    logic [DW-1:0]     avm_readdata;

    logic [AW-1:0]     snoop_addr;
    logic [DW-1:0]     snoop_data;
    logic [BE-1:0]     snoop_be;
    logic              snoop_we;

    modport master (
        input  req_do, req_we, req_addr, req_len, req_be, req_wdata,
        input  avm_waitrequest, avm_readdatavalid, avm_readdata,
        output wr_ack, rd_valid, rd_data, done,
        output avm_address, avm_writedata, avm_byteenable, avm_burstcount, avm_write, avm_read,
        output snoop_addr, snoop_data, snoop_be, snoop_we
    );

    modport slave (
        output req_do, req_we, req_addr, req_len, req_be, req_wdata,
        output avm_waitrequest, avm_readdatavalid, avm_readdata,
        input  wr_ack, rd_valid, rd_data, done,
        input  avm_address, avm_writedata, avm_byteenable, avm_burstcount, avm_write, avm_read,
        input  snoop_addr, snoop_data, snoop_be, snoop_we
    );
endinterface

// File: rtl/avalon_mem_arb.sv
// N-channel burst arbiter onto one Avalon-MM master port with zero-cycle command issue
// from IDLE, round-robin or fixed-priority grant, and a write snoop tap.
module avalon_mem_arb #(
    parameter int NCH       = 4,
    parameter int DW        = 32,
    parameter int AW        = 30,
    parameter int BURST_MAX = 8,
    parameter int RR        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    avalon_mem_arb_if.master bus
);
    localparam int BE = DW / 8;
    localparam int LW = $clog2(BURST_MAX) + 1;
    localparam int GW = $clog2(NCH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [GW-1:0]   r_gnt, w_gnt_nxt;
    logic [GW-1:0]   r_ptr, w_ptr_nxt;
    logic            r_hold, w_hold_nxt;
    logic [AW-1:0]   r_base, w_base_nxt;
    logic [BE-1:0]   r_be, w_be_nxt;
    logic [LW-1:0]   r_len, w_len_nxt;
    logic [LW-1:0]   r_cnt, w_cnt_nxt;
    logic [LW-1:0]   r_beat, w_beat_nxt;

    logic [GW-1:0]   w_arb;
    logic [GW-1:0]   w_gnt;
    logic [GW-1:0]   w_sel;
    logic            w_cmd;
    logic [NCH-1:0]  w_oh;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [LW-1:0]   w_len_raw;
    logic [LW-1:0]   w_len_eff;
    logic [BE-1:0]   w_be;
    logic [DW-1:0]   w_wdata;

    // Grant search: first requester scanning upward from ptr+1 (RR) or from index 0
    always_comb begin
        int  idx;
        int  k;
        logic found;
        w_arb = {GW{1'b0}};
        found = 1'b0;
        idx   = 0;
        k     = 0;
        for (int i = 0; i < NCH; i++) begin
            k     = (RR != 0) ? (int'(r_ptr) + 1 + i) : i;
            idx   = (k >= NCH) ? (k - NCH) : k;
            w_arb = (!found && bus.req_do[idx]) ? GW'(idx) : w_arb;
            found = found | bus.req_do[idx];
        end
    end

    // A held command keeps its grant so a new requester cannot steal the bus mid-handshake
    assign w_gnt = r_hold ? r_gnt : w_arb;
    assign w_cmd = rst_n & (r_hold | (|bus.req_do));
    assign w_sel = (r_state == IDLE) ? w_gnt : r_gnt;
    assign w_oh  = {{(NCH-1){1'b0}}, 1'b1} << w_sel;

    assign w_we      = bus.req_we[w_sel];
    assign w_addr    = bus.req_addr[int'(w_sel)*AW +: AW];
    assign w_len_raw = bus.req_len[int'(w_sel)*LW +: LW];
    assign w_be      = bus.req_be[int'(w_sel)*BE +: BE];
    assign w_wdata   = bus.req_wdata[int'(w_sel)*DW +: DW];
    assign w_len_eff = (w_len_raw == {LW{1'b0}}) ? LW'(1) : w_len_raw;

    // Next-state, burst bookkeeping and all bus/requestor outputs
    always_comb begin
        w_state_nxt        = r_state;
        w_gnt_nxt          = r_gnt;
        w_ptr_nxt          = r_ptr;
        w_hold_nxt         = r_hold;
        w_base_nxt         = r_base;
        w_be_nxt           = r_be;
        w_len_nxt          = r_len;
        w_cnt_nxt          = r_cnt;
        w_beat_nxt         = r_beat;
        bus.wr_ack         = {NCH{1'b0}};
        bus.rd_valid       = {NCH{1'b0}};
        bus.rd_data        = {DW{1'b0}};
        bus.done           = {NCH{1'b0}};
        bus.avm_address    = {AW{1'b0}};
        bus.avm_writedata  = {DW{1'b0}};
        bus.avm_byteenable = {BE{1'b0}};
        bus.avm_burstcount = {LW{1'b0}};
        bus.avm_write      = 1'b0;
        bus.avm_read       = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_cmd) begin
                    bus.avm_address    = w_addr;
                    bus.avm_burstcount = w_len_eff;
                    bus.avm_byteenable = w_be;
                    bus.avm_writedata  = w_wdata;
                    bus.avm_write      = w_we;
                    bus.avm_read       = ~w_we;
                    w_gnt_nxt          = w_gnt;
                    if (!bus.avm_waitrequest) begin
                        w_hold_nxt = 1'b0;
                        w_base_nxt = w_addr;
                        w_be_nxt   = w_be;
                        w_len_nxt  = w_len_eff;
                        if (w_we) begin
                            bus.wr_ack = w_oh;
                            if (w_len_eff == LW'(1)) begin
                                bus.done  = w_oh;
                                w_ptr_nxt = w_gnt;
                            end else begin
                                w_state_nxt = WRITE;
                                w_cnt_nxt   = w_len_eff - LW'(1);
                                w_beat_nxt  = LW'(1);
                            end
                        end else begin
                            w_state_nxt = READ;
                            w_cnt_nxt   = w_len_eff;
                            w_beat_nxt  = {LW{1'b0}};
                        end
                    end else begin
                        w_hold_nxt = 1'b1;
                    end
                end else begin
                    w_hold_nxt = 1'b0;
                end
            end
            WRITE: begin
                bus.avm_address    = r_base;
                bus.avm_burstcount = r_len;
                bus.avm_byteenable = r_be;
                bus.avm_writedata  = w_wdata;
                bus.avm_write      = 1'b1;
                if (!bus.avm_waitrequest) begin
                    bus.wr_ack = w_oh;
                    w_cnt_nxt  = r_cnt - LW'(1);
                    w_beat_nxt = r_beat + LW'(1);
                    if (r_cnt == LW'(1)) begin
                        bus.done    = w_oh;
                        w_ptr_nxt   = r_gnt;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = WRITE;
                    end
                end else begin
                    w_state_nxt = WRITE;
                end
            end
            READ: begin
                if (bus.avm_readdatavalid) begin
                    bus.rd_valid = w_oh;
                    bus.rd_data  = bus.avm_readdata;
                    w_cnt_nxt    = r_cnt - LW'(1);
                    if (r_cnt == LW'(1)) begin
                        bus.done    = w_oh;
                        w_ptr_nxt   = r_gnt;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = READ;
                    end
                end else begin
                    w_state_nxt = READ;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Snoop tap: in IDLE the beat index is zero so the address equals the command address
    assign bus.snoop_we   = bus.avm_write & ~bus.avm_waitrequest;
    assign bus.snoop_data = bus.avm_writedata;
    assign bus.snoop_be   = bus.avm_byteenable;
    assign bus.snoop_addr = (r_state == WRITE) ? (r_base + AW'(r_beat)) : bus.avm_address;

    // State and burst context registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_gnt   <= {GW{1'b0}};
            r_ptr   <= GW'(NCH - 1);
            r_hold  <= 1'b0;
            r_base  <= {AW{1'b0}};
            r_be    <= {BE{1'b0}};
            r_len   <= {LW{1'b0}};
            r_cnt   <= {LW{1'b0}};
            r_beat  <= {LW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_base  <= w_base_nxt;
            r_be    <= w_be_nxt;
            r_len   <= w_len_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
        end
    end
endmodule

// File: tb/tb_avalon_mem_arb.sv
// Directed bench for avalon_mem_arb: scoreboard queues of expected write beats and read
// beats, popped by a negedge monitor, plus inline checks of command/reset behaviour.
module tb_avalon_mem_arb;
    localparam int NCH = 4;
    localparam int DW  = 32;
    localparam int AW  = 30;
    localparam int BM  = 8;
    localparam int LW  = 4;
    localparam int BE  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_fail = 0;

    typedef struct {
        int            ch;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [BE-1:0] be;
        bit            last;
    } wr_t;

    typedef struct {
        int            ch;
        logic [DW-1:0] data;
        bit            last;
    } rd_t;

    wr_t q_wr[$];
    rd_t q_rd[$];

    always #5 clk = ~clk;

    avalon_mem_arb_if #(.NCH(NCH), .DW(DW), .AW(AW), .BURST_MAX(BM)) bus ();
    avalon_mem_arb_if #(.NCH(NCH), .DW(DW), .AW(AW), .BURST_MAX(BM)) fp_bus ();

    avalon_mem_arb #(.NCH(NCH), .DW(DW), .AW(AW), .BURST_MAX(BM), .RR(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    avalon_mem_arb #(.NCH(NCH), .DW(DW), .AW(AW), .BURST_MAX(BM), .RR(0)) dut_fp (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (fp_bus)
    );

    assign fp_bus.req_do            = bus.req_do;
    assign fp_bus.req_we            = bus.req_we;
    assign fp_bus.req_addr          = bus.req_addr;
    assign fp_bus.req_len           = bus.req_len;
    assign fp_bus.req_be            = bus.req_be;
    assign fp_bus.req_wdata         = bus.req_wdata;
    assign fp_bus.avm_waitrequest   = bus.avm_waitrequest;
    assign fp_bus.avm_readdatavalid = bus.avm_readdatavalid;
    assign fp_bus.avm_readdata      = bus.avm_readdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic logic [NCH-1:0] oh(input int c);
        oh = NCH'(1) << c;
    endfunction

    task automatic set_ch(input int c, input logic we, input logic [AW-1:0] a,
                          input logic [LW-1:0] len, input logic [BE-1:0] be,
                          input logic [DW-1:0] wd);
        bus.req_we[c]               = we;
        bus.req_addr[c*AW +: AW]    = a;
        bus.req_len[c*LW +: LW]     = len;
        bus.req_be[c*BE +: BE]      = be;
        bus.req_wdata[c*DW +: DW]   = wd;
    endtask

    task automatic push_wr(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [BE-1:0] be, input bit last);
        wr_t e;
        e.ch = c; e.addr = a; e.data = d; e.be = be; e.last = last;
        q_wr.push_back(e);
    endtask

    task automatic push_rd(input int c, input logic [DW-1:0] d, input bit last);
        rd_t e;
        e.ch = c; e.data = d; e.last = last;
        q_rd.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every snooped write beat and every read beat pops one expectation
    always @(negedge clk) begin : mon
        wr_t w;
        rd_t r;
        if (rst_n) begin
            if (bus.snoop_we) begin
                if (q_wr.size() == 0) begin
                    chk("wr_unexpected", bus.snoop_we, 64'd0);
                end else begin
                    w = q_wr.pop_front();
                    chk("wr_ack", bus.wr_ack, oh(w.ch));
                    chk("wr_done", bus.done, w.last ? oh(w.ch) : 4'd0);
                    chk("snoop_addr", bus.snoop_addr, w.addr);
                    chk("snoop_data", bus.snoop_data, w.data);
                    chk("snoop_be", bus.snoop_be, w.be);
                end
            end else if (bus.wr_ack != 4'd0) begin
                chk("wr_ack_stray", bus.wr_ack, 64'd0);
            end
            if (bus.rd_valid != 4'd0) begin
                if (q_rd.size() == 0) begin
                    chk("rd_unexpected", bus.rd_valid, 64'd0);
                end else begin
                    r = q_rd.pop_front();
                    chk("rd_valid", bus.rd_valid, oh(r.ch));
                    chk("rd_data", bus.rd_data, r.data);
                    chk("rd_done", bus.done, r.last ? oh(r.ch) : 4'd0);
                end
            end
            if (bus.done != 4'd0 && !bus.snoop_we && bus.rd_valid == 4'd0) begin
                chk("done_stray", bus.done, 64'd0);
            end
        end
    end

    initial begin
        logic [5:0] pat;
        int         j;
        bus.req_do            = 4'd0;
        bus.req_we            = 4'd0;
        bus.req_addr          = '0;
        bus.req_len           = '0;
        bus.req_be            = '0;
        bus.req_wdata         = '0;
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'd0;

        // Reset with every channel already requesting: nothing may leak onto the bus
        for (int c = 0; c < NCH; c++) set_ch(c, 1'b1, AW'(c * 16), 4'd1, 4'hF, 32'hC0DE_0000 + DW'(c));
        bus.req_do = 4'hF;
        #12;
        chk("rst_write", bus.avm_write, 64'd0);
        chk("rst_read", bus.avm_read, 64'd0);
        chk("rst_wr_ack", bus.wr_ack, 64'd0);
        chk("rst_done", bus.done, 64'd0);
        chk("rst_rd_valid", bus.rd_valid, 64'd0);
        chk("rst_snoop_we", bus.snoop_we, 64'd0);

        // Round-robin from ptr=NCH-1: 0,1,2,3,0 ; fixed priority always channel 0
        push_wr(0, 30'd0,  32'hC0DE_0000, 4'hF, 1'b1);
        push_wr(1, 30'd16, 32'hC0DE_0001, 4'hF, 1'b1);
        push_wr(2, 30'd32, 32'hC0DE_0002, 4'hF, 1'b1);
        push_wr(3, 30'd48, 32'hC0DE_0003, 4'hF, 1'b1);
        push_wr(0, 30'd0,  32'hC0DE_0000, 4'hF, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("fp_ack", fp_bus.wr_ack, 64'd1);
            chk("rr_burstcount", bus.avm_burstcount, 64'd1);
            tick();
        end
        bus.req_do = 4'd0;

        // len=0 write behaves as a single beat
        set_ch(2, 1'b1, 30'h55, 4'd0, 4'b0011, 32'h1234_5678);
        push_wr(2, 30'h55, 32'h1234_5678, 4'b0011, 1'b1);
        bus.req_do = 4'b0100;
        @(negedge clk);
        chk("len0_burstcount", bus.avm_burstcount, 64'd1);
        tick();
        bus.req_do = 4'd0;

        // Three-beat write wrapping the address space, waitrequest on beat 2, req_do dropped
        set_ch(0, 1'b1, 30'h3FFF_FFFF, 4'd3, 4'hF, 32'hA0);
        push_wr(0, 30'h3FFF_FFFF, 32'hA0, 4'hF, 1'b0);
        push_wr(0, 30'h0000_0000, 32'hA1, 4'hF, 1'b0);
        push_wr(0, 30'h0000_0001, 32'hA2, 4'hF, 1'b1);
        bus.req_do = 4'b0001;
        @(negedge clk);
        chk("wb_burstcount", bus.avm_burstcount, 64'd3);
        tick();
        bus.req_wdata[31:0]  = 32'hA1;
        bus.avm_waitrequest  = 1'b1;
        bus.req_do           = 4'd0;
        @(negedge clk);
        chk("wb_hold_write", bus.avm_write, 64'd1);
        chk("wb_hold_addr", bus.avm_address, 64'h3FFF_FFFF);
        chk("wb_hold_bc", bus.avm_burstcount, 64'd3);
        chk("wb_hold_snoop", bus.snoop_we, 64'd0);
        tick();
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
        tick();
        bus.req_wdata[31:0] = 32'hA2;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("wb_idle_write", bus.avm_write, 64'd0);

        // Channel 1 read len=4 at 0x100, command held through two waitrequest cycles
        set_ch(1, 1'b0, 30'h100, 4'd4, 4'hF, 32'd0);
        bus.req_do          = 4'b0010;
        bus.avm_waitrequest = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rd_cmd_read", bus.avm_read, 64'd1);
            chk("rd_cmd_addr", bus.avm_address, 64'h100);
            chk("rd_cmd_bc", bus.avm_burstcount, 64'd4);
            tick();
            if (k == 1) bus.avm_waitrequest = 1'b0;
        end
        for (int b = 0; b < 4; b++) push_rd(1, 32'hD0 + DW'(b), b == 3);
        pat = 6'b101101;
        j   = 0;
        for (int t = 0; t < 6; t++) begin
            bus.avm_readdatavalid = pat[t];
            if (pat[t]) begin
                bus.avm_readdata = 32'hD0 + DW'(j);
                j++;
            end
            @(negedge clk);
            chk("rd_burst_read_low", bus.avm_read, 64'd0);
            tick();
        end
        bus.req_do            = 4'd0;
        bus.avm_readdatavalid = 1'b1;
        bus.avm_readdata      = 32'hBAD;
        @(negedge clk);
        chk("rd_idle_ignored", bus.rd_valid, 64'd0);
        tick();
        bus.avm_readdatavalid = 1'b0;

        // Channel 3 read len=8 interrupted by reset after two beats
        set_ch(3, 1'b0, 30'h200, 4'd8, 4'hF, 32'd0);
        bus.req_do = 4'b1000;
        @(negedge clk);
        chk("rst_rd_cmd", bus.avm_read, 64'd1);
        tick();
        bus.req_do = 4'd0;
        push_rd(3, 32'hE0, 1'b0);
        push_rd(3, 32'hE1, 1'b0);
        for (int t = 0; t < 2; t++) begin
            bus.avm_readdatavalid = 1'b1;
            bus.avm_readdata      = 32'hE0 + DW'(t);
            @(negedge clk);
            tick();
        end
        bus.avm_readdata = 32'hE2;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rd_valid", bus.rd_valid, 64'd0);
        chk("rst_mid_done", bus.done, 64'd0);
        chk("rst_mid_read", bus.avm_read, 64'd0);
        chk("rst_mid_write", bus.avm_write, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stray_rdv", bus.rd_valid, 64'd0);
        chk("rst_stray_done", bus.done, 64'd0);
        tick();
        bus.avm_readdatavalid = 1'b0;

        // After reset ptr=NCH-1, so channel 0 wins over channel 3
        set_ch(0, 1'b1, 30'h40, 4'd1, 4'hF, 32'h11);
        set_ch(3, 1'b1, 30'h80, 4'd1, 4'hF, 32'h33);
        push_wr(0, 30'h40, 32'h11, 4'hF, 1'b1);
        push_wr(3, 30'h80, 32'h33, 4'hF, 1'b1);
        bus.req_do = 4'b1001;
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        bus.req_do = 4'd0;
        @(negedge clk);
        chk("end_write_idle", bus.avm_write, 64'd0);
        chk("q_wr_drained", q_wr.size(), 64'd0);
        chk("q_rd_drained", q_rd.size(), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
